// File: rtl/gpu_primitive_sequencer.sv
// GP0 primitive sequencer: decodes polygon/rectangle/fill packets into load strobes and raster issues.
// Optional issued-primitive counter enabled by defining GPU_SEQ_PRIMCOUNT_EN.
module gpu_primitive_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic        i_clk,
  input  logic        i_nRst,
  input  logic        i_fifoValid,
  input  logic [31:0] i_fifoData,
  output logic        o_fifoRead,
  output logic        o_validData,
  output logic [31:0] o_data,
  output logic [7:0]  o_command,
  output logic [1:0]  o_targetVertex,
  output logic        o_loadVertices,
  output logic        o_loadUV,
  output logic        o_loadRGB,
  output logic        o_loadAllRGB,
  output logic        o_loadCoord1,
  output logic        o_loadSize,
  output logic [1:0]  o_loadSizeParam,
  output logic        o_loadRectEdge,
  output logic        o_isVertexLoadState,
  output logic        o_primIssue,
  output logic [1:0]  o_primKind,
  input  logic        i_rasterDone,
  output logic        o_busy
`ifdef GPU_SEQ_PRIMCOUNT_EN
  ,
  output logic [CNT_W-1:0] o_primCount
`endif
);

  typedef enum logic [2:0] {
    HEADER,
    COLOR,
    VERTEX,
    UV,
    SIZE,
    SETTLE,
    WAIT
  } stateT;

  stateT       state, stateNext;
  logic [7:0]  cmdReg, cmdNext;
  logic [1:0]  vtxIdx, vtxNext;

  logic        validNext, issueNext;
  logic [1:0]  kindNext, tgtNext, paramNext;
  logic        vtxLoadNext, uvLoadNext, rgbNext, allRgbNext, coord1Next;
  logic        sizeNext, rectEdgeNext, vlsNext;

  logic [7:0]  hdr;
  logic        isPoly, isRect, isFill;
  logic        gouraud, quad, textured;
  logic [1:0]  sizeCode, tgtNow;
  logic        polyLast, readState;

  // In HEADER the packet type comes from the word being popped, otherwise from the latched header.
  assign hdr      = (state == HEADER) ? i_fifoData[31:24] : cmdReg;
  assign isPoly   = (hdr[7:5] == 3'b001);
  assign isRect   = (hdr[7:5] == 3'b011);
  assign isFill   = (hdr == 8'h02);
  assign gouraud  = hdr[4];
  assign quad     = hdr[3];
  assign textured = hdr[2];
  assign sizeCode = hdr[4:3];
  assign tgtNow   = (vtxIdx == 2'd3) ? 2'd0 : vtxIdx;
  assign polyLast = (vtxIdx >= 2'd2);

  assign readState  = (state == HEADER) || (state == COLOR) || (state == VERTEX) ||
                      (state == UV) || (state == SIZE);
  assign o_fifoRead = i_fifoValid & readState;
  assign o_busy     = (state != HEADER);
  assign o_command  = cmdReg;

  always_comb begin
    stateNext    = state;
    cmdNext      = cmdReg;
    vtxNext      = vtxIdx;
    validNext    = o_fifoRead;
    issueNext    = 1'b0;
    kindNext     = 2'd0;
    tgtNext      = 2'd0;
    paramNext    = 2'd0;
    vtxLoadNext  = 1'b0;
    uvLoadNext   = 1'b0;
    rgbNext      = 1'b0;
    allRgbNext   = 1'b0;
    coord1Next   = 1'b0;
    sizeNext     = 1'b0;
    rectEdgeNext = 1'b0;
    vlsNext      = 1'b0;

    case (state)
      HEADER: begin
        if (o_fifoRead) begin
          cmdNext = i_fifoData[31:24];
          vtxNext = 2'd0;
          if (isPoly) begin
            rgbNext    = 1'b1;
            allRgbNext = !gouraud;
            stateNext  = VERTEX;
          end else if (isRect || isFill) begin
            rgbNext    = 1'b1;
            allRgbNext = 1'b1;
            stateNext  = VERTEX;
          end
        end
      end
      COLOR: begin
        if (o_fifoRead) begin
          rgbNext   = 1'b1;
          tgtNext   = tgtNow;
          stateNext = VERTEX;
        end
      end
      VERTEX: begin
        if (o_fifoRead) begin
          if (isFill) begin
            coord1Next = 1'b1;
            stateNext  = SIZE;
          end else if (isRect) begin
            vtxLoadNext = 1'b1;
            // Fixed-size rectangles derive their edges from the vertex word itself.
            if (sizeCode != 2'd0) begin
              sizeNext     = 1'b1;
              paramNext    = sizeCode;
              rectEdgeNext = 1'b1;
              vlsNext      = 1'b1;
            end
            if (textured)               stateNext = UV;
            else if (sizeCode == 2'd0)  stateNext = SIZE;
            else                        stateNext = SETTLE;
          end else begin
            vtxLoadNext = 1'b1;
            tgtNext     = tgtNow;
            if (textured) begin
              stateNext = UV;
            end else if (polyLast) begin
              stateNext = SETTLE;
            end else begin
              vtxNext   = vtxIdx + 2'd1;
              stateNext = gouraud ? COLOR : VERTEX;
            end
          end
        end
      end
      UV: begin
        if (o_fifoRead) begin
          uvLoadNext = 1'b1;
          if (isRect) begin
            stateNext = (sizeCode == 2'd0) ? SIZE : SETTLE;
          end else begin
            tgtNext = tgtNow;
            if (polyLast) begin
              stateNext = SETTLE;
            end else begin
              vtxNext   = vtxIdx + 2'd1;
              stateNext = gouraud ? COLOR : VERTEX;
            end
          end
        end
      end
      SIZE: begin
        if (o_fifoRead) begin
          sizeNext     = 1'b1;
          rectEdgeNext = isRect;
          stateNext    = SETTLE;
        end
      end
      SETTLE: begin
        issueNext = 1'b1;
        kindNext  = isRect ? 2'd1 : (isFill ? 2'd2 : 2'd0);
        stateNext = WAIT;
      end
      WAIT: begin
        // A done pulse coincident with the issue pulse belongs to a previous job and is ignored.
        if (i_rasterDone && !o_primIssue) begin
          if (isPoly && quad && (vtxIdx == 2'd2)) begin
            vtxNext   = 2'd3;
            stateNext = gouraud ? COLOR : VERTEX;
          end else begin
            stateNext = HEADER;
          end
        end
      end
      default: stateNext = HEADER;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state               <= HEADER;
      cmdReg              <= 8'd0;
      vtxIdx              <= 2'd0;
      o_validData         <= 1'b0;
      o_data              <= 32'd0;
      o_targetVertex      <= 2'd0;
      o_loadVertices      <= 1'b0;
      o_loadUV            <= 1'b0;
      o_loadRGB           <= 1'b0;
      o_loadAllRGB        <= 1'b0;
      o_loadCoord1        <= 1'b0;
      o_loadSize          <= 1'b0;
      o_loadSizeParam     <= 2'd0;
      o_loadRectEdge      <= 1'b0;
      o_isVertexLoadState <= 1'b0;
      o_primIssue         <= 1'b0;
      o_primKind          <= 2'd0;
    end else begin
      state               <= stateNext;
      cmdReg              <= cmdNext;
      vtxIdx              <= vtxNext;
      o_validData         <= validNext;
      if (o_fifoRead) o_data <= i_fifoData;
      o_targetVertex      <= tgtNext;
      o_loadVertices      <= vtxLoadNext;
      o_loadUV            <= uvLoadNext;
      o_loadRGB           <= rgbNext;
      o_loadAllRGB        <= allRgbNext;
      o_loadCoord1        <= coord1Next;
      o_loadSize          <= sizeNext;
      o_loadSizeParam     <= paramNext;
      o_loadRectEdge      <= rectEdgeNext;
      o_isVertexLoadState <= vlsNext;
      o_primIssue         <= issueNext;
      o_primKind          <= kindNext;
    end
  end

`ifdef GPU_SEQ_PRIMCOUNT_EN
  logic [CNT_W-1:0] primCount;

  // Counts in step with the issue pulse so the new value is visible alongside it.
  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      primCount <= '0;
    end else if (issueNext) begin
      primCount <= primCount + CNT_W'(1);
    end
  end

  assign o_primCount = primCount;
`endif

endmodule
